// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants and transmit FSM state type
package eth_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IPG,
    ST_DRAIN
  } tx_state_t;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: combinational reflected CRC-32 update by one byte, LSB first
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC32_POLY_REFL : crc_out >> 1;
  end
endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: RGMII transmit framer with preamble, padding, FCS, IPG and underrun abort
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int RGMII_W = 8,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IPG_BYTES = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [RGMII_W-1:0] tx_data,
  output logic               tx_valid,
  output logic               tx_underrun
);
  localparam logic [15:0] MIN_C = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] IPG_C = 16'(IPG_BYTES);
  tx_state_t state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [31:0] crc, crc_n, crc_upd, fcs_word;
  logic [7:0] crc_byte, data_n, fcs_byte;
  logic inv, inv_n, valid_n, under_n, short;
  crc32_byte u_crc (
    .crc_in (crc),
    .data_in(crc_byte),
    .crc_out(crc_upd)
  );
  assign s_ready = (state == ST_PAYLOAD) || (state == ST_DRAIN);
  assign crc_byte = (state == ST_PAYLOAD && s_valid) ? s_data : 8'h00;
  assign cnt_inc = (cnt < MIN_C) ? cnt + 16'd1 : cnt;
  assign short = cnt_inc < MIN_C;
  assign fcs_word = inv ? crc : ~crc;
  assign fcs_byte = 8'(fcs_word >> {cnt[1:0], 3'b000});
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    crc_n = crc;
    inv_n = inv;
    data_n = 8'h00;
    valid_n = 1'b0;
    under_n = 1'b0;
    case (state)
      ST_IDLE: if (s_valid) begin
        state_n = ST_PREAMBLE;
        cnt_n = '0;
        data_n = PREAMBLE_BYTE;
        valid_n = 1'b1;
      end
      ST_PREAMBLE: begin
        data_n = PREAMBLE_BYTE;
        valid_n = 1'b1;
        cnt_n = cnt + 16'd1;
        state_n = (cnt == 16'd5) ? ST_SFD : ST_PREAMBLE;
      end
      ST_SFD: begin
        data_n = SFD_BYTE;
        valid_n = 1'b1;
        crc_n = CRC32_INIT;
        cnt_n = '0;
        inv_n = 1'b0;
        state_n = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        valid_n = 1'b1;
        if (s_valid) begin
          data_n = s_data;
          crc_n = crc_upd;
          cnt_n = (s_last && !short) ? '0 : cnt_inc;
          if (s_last) state_n = short ? ST_PAD : ST_FCS;
        end else if (cnt < MIN_C) begin
          inv_n = 1'b1;
          crc_n = crc_upd;
          cnt_n = short ? cnt_inc : '0;
          state_n = short ? ST_PAD : ST_FCS;
        end else begin
          inv_n = 1'b1;
          data_n = crc[7:0];
          under_n = 1'b1;
          cnt_n = 16'd1;
          state_n = ST_FCS;
        end
      end
      ST_PAD: begin
        valid_n = 1'b1;
        crc_n = crc_upd;
        cnt_n = short ? cnt_inc : '0;
        state_n = short ? ST_PAD : ST_FCS;
      end
      ST_FCS: begin
        valid_n = 1'b1;
        data_n = fcs_byte;
        under_n = inv && (cnt[1:0] == 2'd0);
        cnt_n = (cnt[1:0] == 2'd3) ? '0 : cnt + 16'd1;
        state_n = (cnt[1:0] == 2'd3) ? ST_IPG : ST_FCS;
      end
      ST_IPG: begin
        cnt_n = (cnt == IPG_C - 16'd1) ? '0 : cnt + 16'd1;
        if (cnt == IPG_C - 16'd1) state_n = inv ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: if (s_valid && s_last) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      crc <= CRC32_INIT;
      inv <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      crc <= crc_n;
      inv <= inv_n;
      tx_data <= RGMII_W'(data_n);
      tx_valid <= valid_n;
      tx_underrun <= under_n;
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed self-checking bench for eth_tx_framer and crc32_byte
module tb_eth_tx_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_underrun;
  logic [31:0] crc_c, crc_nx;
  logic [7:0] byte_c;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nf = 0;
  int n_under = 0;
  int under_cyc = 0;
  int t0 = 0;
  bit in_fr = 0;
  logic [7:0] fr [8][200];
  int fr_len [8];
  int fr_start [8];
  int fr_end [8];
  logic [7:0] exp_q [$];
  logic [7:0] pay [$];
  logic [7:0] pay2 [$];
  always #4 clk = ~clk;
  eth_tx_framer dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_underrun(tx_underrun)
  );
  crc32_byte u_crc (
    .crc_in(crc_c),
    .data_in(byte_c),
    .crc_out(crc_nx)
  );
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_underrun) begin
      n_under++;
      under_cyc = cyc;
    end
    if (tx_valid && nf < 8) begin
      if (!in_fr) begin
        in_fr = 1;
        fr_start[nf] = cyc;
        fr_len[nf] = 0;
      end
      if (fr_len[nf] < 200) fr[nf][fr_len[nf]] = tx_data;
      fr_len[nf]++;
    end else if (in_fr) begin
      in_fr = 0;
      fr_end[nf] = cyc - 1;
      nf++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] crc_model(input logic [7:0] q [$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) for (int b = 0; b < 8; b++) begin
      logic fb;
      fb = c[0] ^ q[i][b];
      c = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return ~c;
  endfunction
  task automatic push(input logic [7:0] d, input logic l);
    int n = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 2000);
    if (n >= 2000) check("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] q [$]);
    @(posedge clk);
    #1;
    t0 = cyc;
    foreach (q[i]) push(q[i], 1'(i == q.size() - 1));
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic wait_frames(input int n);
    int t = 0;
    while (nf < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("frame_count", nf, n);
  endtask
  task automatic check_frame(input int k, input bit bad);
    logic [31:0] f;
    f = crc_model(exp_q);
    if (bad) f = ~f;
    check($sformatf("f%0d_len", k), fr_len[k], 12 + exp_q.size());
    for (int i = 0; i < 7; i++) check($sformatf("f%0d_pre%0d", k, i), fr[k][i], 8'h55);
    check($sformatf("f%0d_sfd", k), fr[k][7], 8'hD5);
    foreach (exp_q[i]) check($sformatf("f%0d_byte%0d", k, i), fr[k][8+i], exp_q[i]);
    for (int i = 0; i < 4; i++) check($sformatf("f%0d_fcs%0d", k, i), fr[k][8+exp_q.size()+i], f[8*i +: 8]);
  endtask
  initial begin
    string s;
    logic [31:0] r;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_underrun", tx_underrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    s = "123456789";
    crc_c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      byte_c = s[i];
      #1 crc_c = crc_nx;
    end
    r = ~crc_c;
    check("crc_check_value", r, 32'hCBF43926);
    check("crc_fcs_b0", r[7:0], 8'h26);
    check("crc_fcs_b1", r[15:8], 8'h39);
    check("crc_fcs_b2", r[23:16], 8'hF4);
    check("crc_fcs_b3", r[31:24], 8'hCB);
    pay = {};
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    exp_q = pay;
    send(pay);
    wait_frames(1);
    check("first_preamble_cycle", fr_start[0], t0 + 2);
    check_frame(0, 0);
    pay = {8'hAB};
    exp_q = {8'hAB};
    for (int i = 0; i < 59; i++) exp_q.push_back(8'h00);
    send(pay);
    wait_frames(2);
    check_frame(1, 0);
    pay = {};
    pay2 = {};
    for (int i = 0; i < 64; i++) begin
      pay.push_back(8'(i * 3 + 1));
      pay2.push_back(8'(200 - i));
    end
    @(posedge clk);
    #1;
    foreach (pay[i]) push(pay[i], 1'(i == 63));
    foreach (pay2[i]) push(pay2[i], 1'(i == 63));
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_frames(4);
    check("b2b_gap", fr_start[3] - fr_end[2], 13);
    exp_q = pay;
    check_frame(2, 0);
    exp_q = pay2;
    check_frame(3, 0);
    exp_q = {};
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i + 16));
    for (int i = 0; i < 40; i++) exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) push(8'(i + 16), 1'b0);
    s_valid = 1'b0;
    begin
      int t = 0;
      while (n_under == 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    check("underrun_seen", n_under, 1);
    for (int i = 20; i < 100; i++) push(8'(i + 16), 1'(i == 99));
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_frames(5);
    check_frame(4, 1);
    check("underrun_cycle", under_cyc, fr_start[4] + 68);
    repeat (20) @(negedge clk);
    check("drain_no_frame", nf, 5);
    check("underrun_once", n_under, 1);
    check("idle_after_drain", s_ready, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) push(8'(i + 8'h80), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frames(6);
    pay = {8'h11, 8'h22};
    exp_q = pay;
    for (int i = 0; i < 58; i++) exp_q.push_back(8'h00);
    send(pay);
    wait_frames(7);
    check_frame(6, 0);
    check("underrun_total", n_under, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
